// File: rtl/tx_id_pkg.sv
// rtl/tx_id_pkg.sv - shared constants and state type for the TX_ID frame loader
package tx_id_pkg;

    localparam int MAX_TX_ID   = 4;
    localparam int HASH_BYTES  = 32;
    localparam int TX_ID_BUS_W = 1024;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

endpackage

// File: rtl/tx_id_loader.sv
// rtl/tx_id_loader.sv - assembles a count byte plus N*32 hash bytes into a packed TX_ID bus
// Optional mid-frame idle timeout is enabled by defining TX_ID_LOADER_TIMEOUT_EN.
module tx_id_loader
    import tx_id_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [7:0]             rx_byte,
    input  logic                   rx_byte_valid,
    output logic [TX_ID_BUS_W-1:0] TX_ID_input,
    output logic [7:0]             total_TX_ID,
    output logic                   TX_ID_valid,
    output logic                   busy,
    output logic                   frame_error
);

    state_t                 state, state_next;
    logic [TX_ID_BUS_W-1:0] shift_reg;
    logic [TX_ID_BUS_W-1:0] shifted;
    logic [7:0]             byte_cnt;
    logic [2:0]             n_reg;
    logic                   count_ok;
    logic                   start, shift_en, done, reject, abort;
    logic                   timeout_hit;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

`ifdef TX_ID_LOADER_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] idle_timer;

    // Cleared by any strobe, so only consecutive strobe-free LOAD cycles count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_timer <= '0;
        end else if (start || shift_en) begin
            idle_timer <= '0;
        end else if (state == LOAD) begin
            idle_timer <= idle_timer + 1'b1;
        end
    end

    assign timeout_hit = (state == LOAD) && (idle_timer == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    assign count_ok = (rx_byte != 8'd0) && (rx_byte <= 8'(MAX_TX_ID));
    assign shifted  = {shift_reg[TX_ID_BUS_W-9:0], rx_byte};
    assign busy     = (state == LOAD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A strobe always takes priority over a coincident timeout.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        shift_en   = 1'b0;
        done       = 1'b0;
        reject     = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (rx_byte_valid) begin
                    if (count_ok) begin
                        start      = 1'b1;
                        state_next = LOAD;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (rx_byte_valid) begin
                    shift_en = 1'b1;
                    if (byte_cnt == 8'd1) begin
                        done       = 1'b1;
                        state_next = IDLE;
                    end
                end else if (timeout_hit) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg   <= '0;
            byte_cnt    <= '0;
            n_reg       <= '0;
            TX_ID_input <= '0;
            total_TX_ID <= '0;
            TX_ID_valid <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            TX_ID_valid <= done;
            frame_error <= reject | abort;
            if (start) begin
                shift_reg <= '0;
                byte_cnt  <= {rx_byte[2:0], 5'b00000};
                n_reg     <= rx_byte[2:0];
            end else if (shift_en) begin
                shift_reg <= shifted;
                byte_cnt  <= byte_cnt - 8'd1;
            end
            if (done) begin
                TX_ID_input <= shifted;
                total_TX_ID <= {5'b00000, n_reg};
            end
        end
    end

endmodule
